// File: rtl/adder_tree_sched.sv
// Round-robin scheduler time-sharing one adder_tree among NUM_REQ vector sources.
// Tags each issued vector, re-joins the tag with the tree sum, and checks tree sync realignment.
module adder_tree_sched #(
    parameter int NUM_REQ              = 4,
    parameter int REQ_BITS             = 2,
    parameter int PARALLEL_SAMPLE_BITS = 3,
    parameter int INPUT_WIDTH          = 4,
    parameter     IS_SIGNED            = "TRUE",
    parameter int TREE_LATENCY         = 3,
    parameter int OUTPUT_WIDTH         = 7
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 sync,
    input  logic [NUM_REQ-1:0]                                   req_valid,
    input  logic [NUM_REQ*(2**PARALLEL_SAMPLE_BITS)*INPUT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                                   req_ready,
    output logic [(2**PARALLEL_SAMPLE_BITS)*INPUT_WIDTH-1:0]     tree_din,
    output logic                                                 tree_sync,
    input  logic [OUTPUT_WIDTH-1:0]                              tree_dout,
    input  logic                                                 tree_sync_out,
    output logic                                                 res_valid,
    output logic [REQ_BITS-1:0]                                  res_tag,
    output logic [OUTPUT_WIDTH-1:0]                              res_data,
    output logic                                                 sync_err,
    input  logic                                                 clr_err
);

    localparam int PS  = 2 ** PARALLEL_SAMPLE_BITS;
    localparam int VW  = PS * INPUT_WIDTH;
    localparam int LAT = TREE_LATENCY;
    localparam int CW  = (LAT < 1) ? 1 : $clog2(LAT + 1);

    // Sign handling belongs to the tree; these blocks only record which flavour is attached.
    if (IS_SIGNED == "TRUE") begin : g_signed_tree
    end else begin : g_unsigned_tree
    end

    logic [REQ_BITS-1:0] ptr_q, ptr_d;
    logic [REQ_BITS-1:0] base, cand, grant_idx;
    logic                grant_any;
    logic [NUM_REQ-1:0]  ready;
    logic [VW-1:0]       tree_din_q, tree_din_d;
    logic                tree_sync_q, tree_sync_d;
    logic                issue_v_q, issue_v_d;
    logic [REQ_BITS-1:0] issue_tag_q, issue_tag_d;
    logic [CW-1:0]       mask_q, mask_d;
    logic                sync_err_q, sync_err_d;
    logic                line_v, line_sync;
    logic [REQ_BITS-1:0] line_tag;

    always_comb begin
        base      = sync ? '0 : ptr_q;
        cand      = base;
        grant_any = 1'b0;
        grant_idx = base;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = base + REQ_BITS'(k);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        // Grants are withheld while in reset so no source sees a phantom transfer.
        ready = '0;
        if (grant_any && !rst) ready[grant_idx] = 1'b1;
    end

    always_comb begin
        ptr_d       = base;
        tree_din_d  = '0;
        issue_v_d   = 1'b0;
        issue_tag_d = '0;
        tree_sync_d = sync;
        if (grant_any) begin
            ptr_d       = grant_idx + REQ_BITS'(1);
            tree_din_d  = req_data[grant_idx*VW +: VW];
            issue_v_d   = 1'b1;
            issue_tag_d = grant_idx;
        end
    end

    if (LAT == 0) begin : g_no_line
        assign line_v    = issue_v_q;
        assign line_tag  = issue_tag_q;
        assign line_sync = tree_sync_q;
    end else begin : g_line
        logic [LAT-1:0]      v_q, v_d, s_q, s_d;
        logic [REQ_BITS-1:0] tag_q [LAT];
        logic [REQ_BITS-1:0] tag_d [LAT];

        always_comb begin
            v_d      = '0;
            s_d      = '0;
            v_d[0]   = issue_v_q;
            s_d[0]   = tree_sync_q;
            tag_d[0] = issue_tag_q;
            for (int unsigned k = 1; k < LAT; k++) begin
                v_d[k]   = v_q[k-1];
                s_d[k]   = s_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                s_q <= '0;
                for (int unsigned k = 0; k < LAT; k++) tag_q[k] <= '0;
            end else begin
                v_q <= v_d;
                s_q <= s_d;
                for (int unsigned k = 0; k < LAT; k++) tag_q[k] <= tag_d[k];
            end
        end

        assign line_v    = v_q[LAT-1];
        assign line_sync = s_q[LAT-1];
        assign line_tag  = tag_q[LAT-1];
    end

    // The tree itself is not reset, so its sync_out is untrusted until it has flushed.
    always_comb begin
        mask_d     = (mask_q != '0) ? mask_q - CW'(1) : mask_q;
        sync_err_d = sync_err_q;
        if (clr_err) sync_err_d = 1'b0;
        if (mask_q == '0 && tree_sync_out != line_sync) sync_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            tree_din_q  <= '0;
            tree_sync_q <= 1'b0;
            issue_v_q   <= 1'b0;
            issue_tag_q <= '0;
            mask_q      <= CW'(LAT);
            sync_err_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            tree_din_q  <= tree_din_d;
            tree_sync_q <= tree_sync_d;
            issue_v_q   <= issue_v_d;
            issue_tag_q <= issue_tag_d;
            mask_q      <= mask_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign req_ready = ready;
    assign tree_din  = tree_din_q;
    assign tree_sync = tree_sync_q;
    assign res_valid = line_v;
    assign res_tag   = line_tag;
    assign res_data  = tree_dout;
    assign sync_err  = sync_err_q;

endmodule
